// File: rtl/theremin_tone_gen.sv
// theremin_tone_gen: DDS tone source, triangle wave scaled by a 4-bit volume (square option via `TONE_GEN_SQUARE_EN`)
// Latency: tick at T -> sample registered at T+2 -> earliest write_audio_out strobe at T+3
// Backpressure: holds the sample until audio_out_allowed; a newer tick replaces it and bumps drop_count (saturating)
module theremin_tone_gen #(
  parameter int SAMPLE_DIV  = 1042,
  parameter int PHASE_WIDTH = 24,
  parameter int DATA_WIDTH  = 14
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [PHASE_WIDTH-1:0] freq_word,
  input  logic [3:0]             volume,
  input  logic                   audio_out_allowed,
`ifdef TONE_GEN_SQUARE_EN
  input  logic                   wave_sel,
`endif
  output logic [DATA_WIDTH-1:0]  left_channel_audio_out,
  output logic [DATA_WIDTH-1:0]  right_channel_audio_out,
  output logic                   write_audio_out,
  output logic [7:0]             drop_count
);

  localparam int CNT_W = $clog2(SAMPLE_DIV);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_WAIT, S_WRITE} state_t;

  // Full-scale square levels as 15-bit signed values (0x6000 is -8192).
  localparam logic signed [14:0] SQ_HIGH = 15'sd8191;
  localparam logic signed [14:0] SQ_LOW  = 15'sh6000;

  logic [CNT_W-1:0]       r_tick_cnt;
  logic [PHASE_WIDTH-1:0] r_phase;
  logic [DATA_WIDTH-1:0]  r_sample;
  logic [7:0]             r_drop;
  state_t                 r_state;
  state_t                 w_next;
  logic                   w_tick;
  logic                   w_drop;
  logic [14:0]            w_p;
  logic [13:0]            w_t;
  logic signed [14:0]     w_tri;
  logic signed [14:0]     w_s;
  logic signed [17:0]     w_prod;
  logic                   w_unused;

  assign w_tick = (r_tick_cnt == CNT_W'(SAMPLE_DIV - 1));

  // Sample-rate divider: free-running 0..SAMPLE_DIV-1.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + CNT_W'(1);
    end
  end

  // Triangle: top 15 phase bits fold into a 14-bit ramp, recentred around zero.
  assign w_p   = r_phase[PHASE_WIDTH-1 -: 15];
  assign w_t   = w_p[14] ? ~w_p[13:0] : w_p[13:0];
  assign w_tri = $signed({1'b0, w_t}) - 15'sd8192;

`ifdef TONE_GEN_SQUARE_EN
  assign w_s = wave_sel ? (r_phase[PHASE_WIDTH-1] ? SQ_LOW : SQ_HIGH) : w_tri;
`else
  assign w_s = w_tri;
`endif

  // |s * 15| <= 122880 fits 18-bit signed; >>>4 keeps the floor semantics.
  assign w_prod   = $signed({{3{w_s[14]}}, w_s}) * $signed({14'd0, volume});
  assign w_unused = &{1'b0, w_prod[3:0]};

  // State register.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; a tick always restarts the sample, dropping any unaccepted one.
  always_comb begin
    w_next = r_state;
    w_drop = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_tick) w_next = S_CALC;
      end
      S_CALC: begin
        w_next = S_WAIT;
      end
      S_WAIT: begin
        if (w_tick) begin
          w_next = S_CALC;
          w_drop = 1'b1;
        end else if (audio_out_allowed) begin
          w_next = S_WRITE;
        end
      end
      S_WRITE: begin
        if (w_tick) begin
          w_next = S_CALC;
          w_drop = ~audio_out_allowed;
        end else if (audio_out_allowed) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_WAIT;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Sample and phase update once per CALC; inputs are only looked at here.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_phase  <= '0;
      r_sample <= '0;
    end else if (r_state == S_CALC) begin
      if (enable) begin
        r_phase  <= r_phase + freq_word;
        r_sample <= w_prod[DATA_WIDTH+3:4];
      end else begin
        r_sample <= '0;
      end
    end
  end

  // Saturating count of samples replaced before the controller took them.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_drop <= '0;
    end else if (w_drop && (r_drop != 8'hFF)) begin
      r_drop <= r_drop + 8'd1;
    end
  end

  assign left_channel_audio_out  = r_sample;
  assign right_channel_audio_out = r_sample;
  assign write_audio_out         = (r_state == S_WRITE);
  assign drop_count              = r_drop;

endmodule

// File: tb/tb_theremin_tone_gen.sv
// tb_theremin_tone_gen: directed + randomized checks of theremin_tone_gen against an arithmetic reference model
// Timing: inputs driven and outputs sampled on the falling edge; DUT is rising-edge
// Backpressure: audio_out_allowed toggled by the bench to provoke drops and saturation
`timescale 1ns/1ps
module tb_theremin_tone_gen;

  localparam int SD = 8;
  localparam int PW = 24;
  localparam int DW = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          allowed;
  logic [PW-1:0] fw;
  logic [3:0]    vol;
  logic          wsel;
  logic [DW-1:0] left;
  logic [DW-1:0] right;
  logic          wr;
  logic [7:0]    drops;

  int     n_cmp   = 0;
  int     n_fail  = 0;
  int     cyc     = 0;
  int     strobes = 0;
  int     last_wr = 0;
  longint ph_m    = 0;

  always #10 clk = ~clk;

  theremin_tone_gen #(.SAMPLE_DIV(SD), .PHASE_WIDTH(PW), .DATA_WIDTH(DW)) dut (
    .CLOCK_50               (clk),
    .reset                  (rst),
    .enable                 (en),
    .freq_word              (fw),
    .volume                 (vol),
    .audio_out_allowed      (allowed),
`ifdef TONE_GEN_SQUARE_EN
    .wave_sel               (wsel),
`endif
    .left_channel_audio_out (left),
    .right_channel_audio_out(right),
    .write_audio_out        (wr),
    .drop_count             (drops)
  );

  // Cycles since reset release; the sample tick falls on cyc % SD == SD-1.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Running count of observed write strobes.
  always @(negedge clk) begin
    if (wr === 1'b1) strobes <= strobes + 1;
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected sample for a given phase/inputs, straight from the waveform definition.
  function automatic int model(longint ph, logic e, int v, logic sq);
    longint p, lo, t, s, prod, q;
    if (!e) return 0;
    if (sq) begin
      s = (ph < (64'sd1 <<< (PW - 1))) ? 8191 : -8192;
    end else begin
      p  = ph / (64'sd1 <<< (PW - 15));
      lo = p % 16384;
      t  = (p >= 16384) ? (16383 - lo) : lo;
      s  = t - 8192;
    end
    prod = s * v;
    q    = prod / 16;
    if ((prod % 16 != 0) && (prod < 0)) q = q - 1;
    return int'(q);
  endfunction

  // One sample period of the model: sample from the current phase, then advance.
  task automatic next_exp(output int e);
    e = model(ph_m, en, int'(vol), wsel);
    if (en) ph_m = (ph_m + longint'(fw)) % (64'sd1 <<< PW);
  endtask

  // Advance to the falling edge inside the next tick cycle.
  task automatic tick_wait();
    for (int k = 0; k < 2 * SD; k++) begin
      @(negedge clk);
      if (cyc % SD == SD - 1) return;
    end
  endtask

  task automatic expect_write(input string tag, input int exp);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 3 * SD && !got; k++) begin
      @(negedge clk);
      if (wr === 1'b1) got = 1'b1;
    end
    chk({tag, "_strobe"}, got, 1);
    if (got) begin
      chk({tag, "_left"}, $signed(left), exp);
      chk({tag, "_right"}, $signed(right), exp);
      last_wr = cyc;
      @(negedge clk);
      chk({tag, "_single"}, wr, 0);
    end
  endtask

  initial begin
    int e, prev, base;
    rst = 1'b1; en = 1'b0; allowed = 1'b0; fw = 24'h400000; vol = 4'd15; wsel = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset values hold until the first tick.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rst_left", $signed(left), 0);
      chk("rst_right", $signed(right), 0);
      chk("rst_wr", wr, 0);
      chk("rst_drop", drops, 0);
    end
    // Disabled and blocked: two ticks, the second one replaces the pending zero sample.
    while (cyc < 20) @(negedge clk);
    chk("rst_idle_strobes", strobes, 0);
    chk("rst_idle_drop", drops, 1);
    chk("rst_idle_left", $signed(left), 0);

    // Triangle sequence and handshake timing from phase 0.
    rst = 1'b1; allowed = 1'b1; en = 1'b1; fw = 24'h400000; vol = 4'd15;
    repeat (2) @(negedge clk);
    rst = 1'b0; ph_m = 0;
    chk("post_rst_drop", drops, 0);
    tick_wait();
    @(negedge clk); chk("hs_t1_wr", wr, 0);
    @(negedge clk); chk("hs_t2_wr", wr, 0); chk("hs_t2_left", $signed(left), -7680);
    @(negedge clk); chk("hs_t3_wr", wr, 1); chk("hs_t3_left", $signed(left), -7680);
    chk("hs_t3_right", $signed(right), -7680);
    prev = cyc;
    @(negedge clk); chk("hs_t4_wr", wr, 0);
    next_exp(e);
    next_exp(e); expect_write("tri_2", 0);     chk("tri_2_period", last_wr - prev, SD); prev = last_wr;
    next_exp(e); expect_write("tri_3", 7679);  chk("tri_3_period", last_wr - prev, SD); prev = last_wr;
    next_exp(e); expect_write("tri_4", -1);    chk("tri_4_period", last_wr - prev, SD);

    // Randomized pitch/volume/enable against the model.
    for (int i = 0; i < 12; i++) begin
      fw  = PW'($urandom);
      vol = 4'($urandom_range(0, 15));
      en  = ($urandom_range(0, 3) != 0);
      next_exp(e);
      expect_write("rnd", e);
    end
    // Zero volume, then disabled (phase must stay put), then back on.
    en = 1'b1; vol = 4'd0; fw = PW'($urandom);
    for (int i = 0; i < 2; i++) begin next_exp(e); expect_write("vol0", 0); end
    en = 1'b0; vol = 4'd15;
    for (int i = 0; i < 3; i++) begin next_exp(e); expect_write("dis", 0); end
    en = 1'b1;
    next_exp(e); expect_write("reen", e);

    // Backpressure: three blocked ticks give two drops, then the newest sample goes out.
    allowed = 1'b0; base = strobes;
    for (int i = 0; i < 3; i++) begin tick_wait(); next_exp(e); end
    repeat (2) @(negedge clk);
    chk("bp_no_strobe", strobes, base);
    chk("bp_drop", drops, 2);
    allowed = 1'b1;
    expect_write("bp_newest", e);
    chk("bp_one_write", strobes, base + 1);
    chk("bp_drop_after", drops, 2);

    // Long stall saturates the drop counter.
    allowed = 1'b0; base = strobes;
    for (int i = 0; i < 300; i++) begin tick_wait(); next_exp(e); end
    repeat (2) @(negedge clk);
    chk("sat_no_strobe", strobes, base);
    chk("sat_drop", drops, 255);
    allowed = 1'b1;
    expect_write("sat_newest", e);
    chk("sat_drop_after", drops, 255);

    // Reset while a sample is pending: no strobe after it, counters cleared.
    allowed = 1'b0;
    tick_wait();
    repeat (2) @(negedge clk);
    rst = 1'b1; allowed = 1'b1;
    @(negedge clk); chk("rst_mid_wr", wr, 0);
    rst = 1'b0; ph_m = 0;
    @(negedge clk); chk("rst_mid_wr2", wr, 0); chk("rst_mid_drop", drops, 0);
    chk("rst_mid_left", $signed(left), 0);

    // Phase wrap: all-ones increment walks the phase backwards.
    en = 1'b1; vol = 4'd15; fw = 24'hFFFFFF;
    next_exp(e); expect_write("wrap_0", -7680);
    for (int i = 0; i < 5; i++) begin next_exp(e); expect_write("wrap", e); end

`ifdef TONE_GEN_SQUARE_EN
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; ph_m = 0; wsel = 1'b1; fw = 24'h800000; vol = 4'd15;
    for (int i = 0; i < 4; i++) begin
      next_exp(e);
      expect_write("square", (i % 2 == 0) ? 7679 : -7680);
    end
    wsel = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
